ps2_kbd_ctrl: RTL and testbench

Memory-mapped PS/2 keyboard receiver. It deserialises scan-code frames from the keyboard's PS/2 clock and data lines, filters key-release sequences and buffers bytes in a small FIFO. It presents the processor-side KBSR/KBDR interface at addresses 0xFE00/0xFE02 and drops in where the push-button keyboard stub sits in the system top level. It runs entirely on the processor clock; the PS/2 pins are treated as asynchronous inputs.

---
 rtl/ps2_kbd_ctrl_if.sv | 32 +++
 rtl/ps2_kbd_ctrl.sv | 253 +++++++++++++++++++++++++
 tb/tb_ps2_kbd_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_kbd_ctrl_if.sv
// rtl/ps2_kbd_ctrl_if.sv - processor-side and PS/2 pin bundle for the keyboard receiver
// Signals:
//   ps2_clk, ps2_data  raw PS/2 pins (asynchronous to clk)
//   gwe                global write enable, qualifies reads
//   read_kbsr          processor load from 0xFE00 this cycle
//   read_kbdr          processor load from 0xFE02 this cycle
//   kbsr               FIFO non-empty
//   kbdr               FIFO head byte, 0x00 when empty
//   overflow           sticky byte-dropped flag
//   frame_err          one-cycle pulse on a bad or timed-out frame
// master: the system side driving pins and reads; slave: the receiver.
interface ps2_kbd_ctrl_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic       gwe;
    logic       read_kbsr;
    logic       read_kbdr;
    logic       kbsr;
    logic [7:0] kbdr;
    logic       overflow;
    logic       frame_err;

    modport master (
        output ps2_clk, ps2_data, gwe, read_kbsr, read_kbdr,
        input  kbsr, kbdr, overflow, frame_err
    );

    modport slave (
        input  ps2_clk, ps2_data, gwe, read_kbsr, read_kbdr,
        output kbsr, kbdr, overflow, frame_err
    );
endinterface

// File: rtl/ps2_kbd_ctrl.sv
// rtl/ps2_kbd_ctrl.sv - memory-mapped PS/2 keyboard receiver with break filter and FIFO
// Ports:
//   clk    processor clock; everything runs in this domain
//   rst_n  asynchronous active-low reset
//   bus    ps2_kbd_ctrl_if.slave: PS/2 pins, KBSR/KBDR reads, status outputs
// Parameters:
//   FIFO_DEPTH      buffered bytes (power of 2, >= 2)
//   FILTER_BREAK    1: drop 0xF0 and the byte after it
//   TIMEOUT_CYCLES  max clk cycles between PS/2 clock falls inside a frame
module ps2_kbd_ctrl #(
    parameter int FIFO_DEPTH     = 4,
    parameter bit FILTER_BREAK   = 1'b1,
    parameter int TIMEOUT_CYCLES = 16000
) (
    input  logic           clk,
    input  logic           rst_n,
    ps2_kbd_ctrl_if.slave  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } rx_state_t;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic       clk_s1, clk_s2;
    logic       dat_s1, dat_s2;
    logic [3:0] clk_hist;
    logic       clk_filt;
    logic       filt_now;
    logic       fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
            clk_hist <= 4'hF;
            clk_filt <= 1'b1;
        end else begin
            clk_s1   <= bus.ps2_clk;
            clk_s2   <= clk_s1;
            dat_s1   <= bus.ps2_data;
            dat_s2   <= dat_s1;
            clk_hist <= {clk_hist[2:0], clk_s2};
            clk_filt <= filt_now;
        end
    end

    // filt_now is the filtered clock for this cycle; clk_filt holds last
    // cycle's value, so fall fires in the cycle the history becomes all 0s.
    always_comb begin
        filt_now = clk_filt;
        if (clk_hist == 4'h0) begin
            filt_now = 1'b0;
        end else if (clk_hist == 4'hF) begin
            filt_now = 1'b1;
        end
    end

    assign fall = clk_filt & ~filt_now;

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    rx_state_t     state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_q, par_d;
    logic [WW-1:0] wd_q, wd_d;
    logic          rx_good;
    logic          rx_err;
    logic          frame_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= 3'd0;
            shreg_q     <= 8'h00;
            par_q       <= 1'b0;
            wd_q        <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            par_q       <= par_d;
            wd_q        <= wd_d;
            frame_err_q <= rx_err;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        wd_d      = '0;
        rx_good   = 1'b0;
        rx_err    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A sampled 1 here is line noise or an idle bit, not an error.
                if (fall && !dat_s2) begin
                    state_d   = S_DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            S_DATA: begin
                if (fall) begin
                    shreg_d   = {dat_s2, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (fall) begin
                    par_d   = dat_s2;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (fall) begin
                    if (dat_s2 && (^{shreg_q, par_q})) begin
                        rx_good = 1'b1;
                    end else begin
                        rx_err = 1'b1;
                    end
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Watchdog: counts clk cycles since the last fall while mid-frame.
        if (state_q != S_IDLE && !fall) begin
            if (wd_q == WD_LAST) begin
                state_d = S_IDLE;
                shreg_d = 8'h00;
                rx_err  = 1'b1;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Break filter
    // ------------------------------------------------------------------
    logic brk_pend_q, brk_pend_d;
    logic push;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            brk_pend_q <= 1'b0;
        end else begin
            brk_pend_q <= brk_pend_d;
        end
    end

    // Only good frames reach this stage, so errored frames leave brk_pend alone.
    always_comb begin
        push       = 1'b0;
        brk_pend_d = brk_pend_q;
        if (rx_good) begin
            if (FILTER_BREAK) begin
                if (brk_pend_q) begin
                    brk_pend_d = 1'b0;
                end else if (shreg_q == 8'hF0) begin
                    brk_pend_d = 1'b1;
                end else begin
                    push = 1'b1;
                end
            end else begin
                push = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          kbsr_i;
    logic          full;
    logic          pop;
    logic          wr_en;
    logic          drop;
    logic          overflow_q;

    assign kbsr_i = (count != '0);
    assign full   = (count == DEPTH_C);
    // Gating on gwe keeps stalled or repeated instruction phases from double-popping.
    assign pop    = bus.read_kbdr & bus.gwe & kbsr_i;
    // A same-cycle pop frees the slot the push needs, even when full.
    assign wr_en  = push & (~full | pop);
    assign drop   = push & full & ~pop;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= shreg_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A drop in the same cycle as a status read keeps the flag set.
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (bus.read_kbsr && bus.gwe) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign bus.kbsr      = kbsr_i;
    assign bus.kbdr      = kbsr_i ? mem[rd_ptr] : 8'h00;
    assign bus.overflow  = overflow_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// tb/tb_ps2_kbd_ctrl.sv - self-checking bench for ps2_kbd_ctrl
module tb_ps2_kbd_ctrl;
    localparam int HALF = 40;
    localparam int TMO  = 200;

    logic clk = 1'b0;
    logic rst_n;
    logic ps2c;
    logic ps2d;

    always #5 clk = ~clk;

    ps2_kbd_ctrl_if if0 ();
    ps2_kbd_ctrl_if if1 ();

    assign if0.ps2_clk  = ps2c;
    assign if0.ps2_data = ps2d;
    assign if1.ps2_clk  = ps2c;
    assign if1.ps2_data = ps2d;

    ps2_kbd_ctrl #(.FIFO_DEPTH(4), .FILTER_BREAK(1'b1), .TIMEOUT_CYCLES(TMO)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave)
    );

    ps2_kbd_ctrl #(.FIFO_DEPTH(4), .FILTER_BREAK(1'b0), .TIMEOUT_CYCLES(TMO)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave)
    );

    int checks  = 0;
    int errors  = 0;
    int err_cnt = 0;
    logic [7:0] exp0[$];
    logic [7:0] exp1[$];

    always @(negedge clk) begin
        if (if0.frame_err === 1'b1) err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2d = b;
        repeat (HALF) @(negedge clk);
        ps2c = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2c = 1'b1;
    endtask

    // pop_at_stop pops dut0 in exactly the cycle the stop-bit fall pushes.
    task automatic send_frame(input logic [7:0] b, input logic bad_par,
                              input logic bad_stop, input logic pop_at_stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2d = ~bad_stop;
        repeat (HALF) @(negedge clk);
        ps2c = 1'b0;
        if (pop_at_stop) begin
            repeat (6) @(negedge clk);
            chk("wrap_head", {24'h0, if0.kbdr}, {24'h0, exp0[0]});
            void'(exp0.pop_front());
            if0.read_kbdr = 1'b1;
            if0.gwe       = 1'b1;
            @(negedge clk);
            if0.read_kbdr = 1'b0;
            if0.gwe       = 1'b0;
            repeat (HALF - 7) @(negedge clk);
        end else begin
            repeat (HALF) @(negedge clk);
        end
        ps2c = 1'b1;
        ps2d = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic pop_chk(input int which, input string tag);
        logic [7:0] e;
        if (which == 0) begin
            e = (exp0.size() > 0) ? exp0.pop_front() : 8'h00;
            chk({tag, "_kbsr"}, {31'h0, if0.kbsr}, 32'h1);
            chk(tag, {24'h0, if0.kbdr}, {24'h0, e});
            if0.read_kbdr = 1'b1;
            if0.gwe       = 1'b1;
            @(negedge clk);
            if0.read_kbdr = 1'b0;
            if0.gwe       = 1'b0;
        end else begin
            e = (exp1.size() > 0) ? exp1.pop_front() : 8'h00;
            chk({tag, "_kbsr"}, {31'h0, if1.kbsr}, 32'h1);
            chk(tag, {24'h0, if1.kbdr}, {24'h0, e});
            if1.read_kbdr = 1'b1;
            if1.gwe       = 1'b1;
            @(negedge clk);
            if1.read_kbdr = 1'b0;
            if1.gwe       = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        exp0.delete();
        exp1.delete();
    endtask

    initial begin
        #3ms;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int e;
        ps2c = 1'b1;
        ps2d = 1'b1;
        if0.gwe = 1'b0; if0.read_kbsr = 1'b0; if0.read_kbdr = 1'b0;
        if1.gwe = 1'b0; if1.read_kbsr = 1'b0; if1.read_kbdr = 1'b0;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_kbsr",      {31'h0, if0.kbsr},      32'h0);
        chk("rst_kbdr",      {24'h0, if0.kbdr},      32'h0);
        chk("rst_overflow",  {31'h0, if0.overflow},  32'h0);
        chk("rst_frame_err", {31'h0, if0.frame_err}, 32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Good frame, gwe-qualified reads
        exp0.push_back(8'h1C);
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        if0.read_kbdr = 1'b1;
        repeat (3) @(negedge clk);
        if0.read_kbdr = 1'b0;
        chk("nogwe_kbsr", {31'h0, if0.kbsr}, 32'h1);
        pop_chk(0, "t1_pop");
        chk("t1_empty_kbsr", {31'h0, if0.kbsr}, 32'h0);
        chk("t1_empty_kbdr", {24'h0, if0.kbdr}, 32'h0);

        // Break filter on dut0, pass-through on dut1
        do_reset();
        exp0.push_back(8'h1C); exp0.push_back(8'h32);
        exp1.push_back(8'h1C); exp1.push_back(8'hF0);
        exp1.push_back(8'h1C); exp1.push_back(8'h32);
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        send_frame(8'h32, 1'b0, 1'b0, 1'b0);
        pop_chk(0, "brk0_a");
        pop_chk(0, "brk0_b");
        chk("brk0_empty", {31'h0, if0.kbsr}, 32'h0);
        for (int i = 0; i < 4; i++) pop_chk(1, "brk1");
        chk("brk1_empty", {31'h0, if1.kbsr}, 32'h0);

        // Errored frame between 0xF0 and its key code leaves brk_pend set
        exp0.push_back(8'h34);
        exp1.push_back(8'hF0); exp1.push_back(8'h33); exp1.push_back(8'h34);
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h44, 1'b1, 1'b0, 1'b0);
        send_frame(8'h33, 1'b0, 1'b0, 1'b0);
        send_frame(8'h34, 1'b0, 1'b0, 1'b0);
        pop_chk(0, "brk_err_keep");
        chk("brk_err_empty", {31'h0, if0.kbsr}, 32'h0);
        for (int i = 0; i < 3; i++) pop_chk(1, "brk1_err");

        // Frame errors
        e = err_cnt;
        send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
        chk("par_err_pulse", err_cnt, e + 1);
        chk("par_err_kbsr",  {31'h0, if0.kbsr}, 32'h0);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        chk("stop_err_pulse", err_cnt, e + 2);
        chk("stop_err_kbsr",  {31'h0, if0.kbsr}, 32'h0);
        exp0.push_back(8'h29);
        send_frame(8'h29, 1'b0, 1'b0, 1'b0);
        pop_chk(0, "after_err");

        // Overflow
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp0.push_back(8'(i));
            send_frame(8'(i), 1'b0, 1'b0, 1'b0);
        end
        chk("ovf_set", {31'h0, if0.overflow}, 32'h1);
        if0.read_kbsr = 1'b1;
        if0.gwe       = 1'b1;
        @(negedge clk);
        if0.read_kbsr = 1'b0;
        if0.gwe       = 1'b0;
        chk("ovf_clear", {31'h0, if0.overflow}, 32'h0);
        for (int i = 0; i < 4; i++) pop_chk(0, "ovf_pop");
        chk("ovf_empty", {31'h0, if0.kbsr}, 32'h0);

        // Full FIFO, push and pop in the same cycle, across pointer wrap
        for (int i = 0; i < 4; i++) begin
            exp0.push_back(8'h11 + 8'(i));
            send_frame(8'h11 + 8'(i), 1'b0, 1'b0, 1'b0);
        end
        exp0.push_back(8'h15);
        send_frame(8'h15, 1'b0, 1'b0, 1'b1);
        chk("wrap_no_ovf", {31'h0, if0.overflow}, 32'h0);
        for (int i = 0; i < 4; i++) pop_chk(0, "wrap_pop");
        chk("wrap_empty", {31'h0, if0.kbsr}, 32'h0);

        // Timeout mid-frame
        e = err_cnt;
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2d = 1'b1;
        repeat (TMO + 50) @(negedge clk);
        chk("tmo_pulse", err_cnt, e + 1);
        chk("tmo_kbsr",  {31'h0, if0.kbsr}, 32'h0);
        exp0.push_back(8'h1C);
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        pop_chk(0, "after_tmo");

        // Reset during data bit 4 with two bytes buffered
        exp0.push_back(8'h41); exp0.push_back(8'h42);
        send_frame(8'h41, 1'b0, 1'b0, 1'b0);
        send_frame(8'h42, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_kbsr", {31'h0, if0.kbsr}, 32'h1);
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(i[0]);
        ps2d = 1'b1;
        repeat (HALF / 2) @(negedge clk);
        e = err_cnt;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_kbsr",     {31'h0, if0.kbsr},     32'h0);
        chk("mid_rst_kbdr",     {24'h0, if0.kbdr},     32'h0);
        chk("mid_rst_overflow", {31'h0, if0.overflow}, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ps2c = 1'b1;
        ps2d = 1'b1;
        exp0.delete();
        exp1.delete();
        repeat (20) @(negedge clk);
        chk("mid_rst_no_err", err_cnt, e);
        exp0.push_back(8'h1C);
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        pop_chk(0, "after_rst");
        chk("final_empty", {31'h0, if0.kbsr}, 32'h0);

        repeat (10) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
